mac_tile_ctrl: RTL and testbench

Sequencer that runs one dot-product job on a single mac_tile instance. It accepts a start command with a chunk count K, then streams K operand chunks (pr lanes of signed bw-bit a/b) into the tile through a valid/ready handshake. It tracks the tile's 2-stage pipeline with a shadow valid pipe, accumulates the tile's partial sums into a wide accumulator, and presents the final result on a valid/ready output. It sits between the operand buffers (L0/SRAM readers) and the output/psum writer.

---
 rtl/mac_tile_ctrl.sv | 152 +++++++++++++++
 tb/tb_mac_tile_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mac_tile_ctrl.sv
// mac_tile_ctrl
// -------------
// Runs one dot-product job on a single mac_tile. A start command carries the
// chunk count K. The controller then accepts K operand chunks and forwards
// each one to the tile. It follows the tile's two-stage latency with a shadow
// valid pipe (v0, v1) and adds each tile partial sum into a wide signed
// accumulator. The final sum is presented on a valid/ready result port.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in RUN. res_valid is high only in DONE and
// holds res_data stable until res_ready is seen. Neither ready nor valid
// depends combinationally on its partner.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   start, num_chunks        job request and chunk count K (sampled in IDLE)
//   busy                     high in any state other than IDLE
//   in_valid/in_ready        operand chunk handshake
//   in_a, in_b               pr lanes of signed bw-bit operands
//   tile_a, tile_b           operands to the tile (zero when not firing)
//   tile_out                 signed partial sum from the tile
//   res_valid/res_ready      result handshake
//   res_data                 signed accumulated dot product
module mac_tile_ctrl #(
  parameter int pr      = 8,
  parameter int bw      = 8,
  parameter int bw_psum = 2 * bw + 3,
  parameter int cnt_bw  = 8,
  parameter int bw_acc  = bw_psum + cnt_bw
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [cnt_bw-1:0]    num_chunks,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [pr*bw-1:0]     in_a,
  input  logic [pr*bw-1:0]     in_b,
  output logic [pr*bw-1:0]     tile_a,
  output logic [pr*bw-1:0]     tile_b,
  input  logic [bw_psum-1:0]   tile_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [bw_acc-1:0]    res_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [cnt_bw-1:0]  k_q, k_d;
  logic [cnt_bw-1:0]  issued_q, issued_d;
  logic [cnt_bw-1:0]  issued_inc;
  logic               v0_q, v0_d;
  logic               v1_q, v1_d;
  logic [bw_acc-1:0]  acc_q, acc_d;
  logic [bw_acc-1:0]  tile_sext;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               res_valid_q, res_valid_d;
  logic               fire;

  assign fire       = in_valid & in_ready_q;
  assign issued_inc = issued_q + {{(cnt_bw-1){1'b0}}, 1'b1};
  assign tile_sext  = {{(bw_acc-bw_psum){tile_out[bw_psum-1]}}, tile_out};

  // The tile sees zeros on non-fire cycles. Gap cycles therefore push a zero
  // partial sum through the tile. That sum is also never accumulated, because
  // v0 is low for those cycles.
  assign tile_a = fire ? in_a : '0;
  assign tile_b = fire ? in_b : '0;

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    issued_d = issued_q;
    v0_d     = 1'b0;
    // v1 marks the cycle in which tile_out holds the sum of a real chunk.
    v1_d     = v0_q;
    acc_d    = v1_q ? (acc_q + tile_sext) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          if (num_chunks != '0) begin
            k_d      = num_chunks;
            issued_d = '0;
            state_d  = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (fire) begin
          issued_d = issued_inc;
          v0_d     = 1'b1;
          if (issued_inc == k_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // This is the last chunk's accumulation edge: it is in v1, and no
        // chunk is left behind it in v0.
        if (v1_q && !v0_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    in_ready_d  = (state_d == S_RUN);
    res_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      issued_q    <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      issued_q    <= issued_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_mac_tile_ctrl.sv
module tb_mac_tile_ctrl;
  localparam int pr      = 8;
  localparam int bw      = 8;
  localparam int bw_psum = 2 * bw + 3;
  localparam int cnt_bw  = 8;
  localparam int bw_acc  = bw_psum + cnt_bw;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [cnt_bw-1:0]   num_chunks;
  logic                busy;
  logic                in_valid;
  logic                in_ready;
  logic [pr*bw-1:0]    in_a, in_b;
  logic [pr*bw-1:0]    tile_a, tile_b;
  logic [bw_psum-1:0]  tile_out;
  logic                res_valid;
  logic                res_ready;
  logic [bw_acc-1:0]   res_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [bw_acc-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mac_tile_ctrl #(.pr(pr), .bw(bw), .bw_psum(bw_psum), .cnt_bw(cnt_bw), .bw_acc(bw_acc)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_chunks(num_chunks), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .tile_a(tile_a), .tile_b(tile_b), .tile_out(tile_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // ---------------- mac_tile model (two stages, no reset) ----------------
  logic [bw_psum-1:0] tile_sum, tile_p1;
  always_comb begin
    logic signed [bw_psum-1:0] ea, eb;
    tile_sum = '0;
    for (int i = 0; i < pr; i++) begin
      ea = $signed(tile_a[bw*i +: bw]);
      eb = $signed(tile_b[bw*i +: bw]);
      tile_sum = tile_sum + bw_psum'(ea * eb);
    end
  end
  always_ff @(posedge clk) begin
    tile_p1  <= tile_sum;
    tile_out <= tile_p1;
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  function automatic longint sres(input logic [bw_acc-1:0] v);
    return longint'($signed(v));
  endfunction

  // ---------------- job driver ----------------
  // vpat/plen: in_valid pattern while in_ready is high. rdy_hold: cycles
  // res_ready stays low after res_valid. poke: cycle to pulse start mid-job
  // (0 = none). exp_busy: expected busy cycles (0 = unchecked).
  task automatic run_job(input string nm, input int k, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] vpat, input int plen, input int rdy_hold,
                         input int poke, input longint expv, input int exp_busy);
    int fires = 0, cyc = 0, busy_cyc = 0, last_fire = -1, valid_cyc = -1, held = 0, pi = 0;
    bit accepted = 0, done = 0;
    logic [bw_acc-1:0] first_data = '0;
    logic [bw_acc-1:0] expd;
    logic [pr*bw-1:0] pa, pb;
    pa = {pr{a}};
    pb = {pr{b}};
    exp_q.push_back(bw_acc'(expv));
    start = 1'b1; num_chunks = cnt_bw'(k); in_valid = 1'b0; res_ready = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
      if (cyc == poke) num_chunks = 8'd1;
      if (accepted) begin
        expd = exp_q.pop_front();
        check({nm, " res_data"}, sres(first_data), sres(expd));
        check({nm, " idle res_valid"}, res_valid, 0);
        check({nm, " idle busy"}, busy, 0);
        check({nm, " res_data kept in idle"}, sres(res_data), sres(expd));
        done = 1;
      end else begin
        if (busy) busy_cyc++;
        if (res_valid) begin
          if (valid_cyc < 0) begin
            valid_cyc  = cyc;
            first_data = res_data;
          end else begin
            check({nm, " res_data stable"}, sres(res_data), sres(first_data));
          end
          if (held < rdy_hold) begin res_ready = 1'b0; held++; end
          else begin res_ready = 1'b1; accepted = 1; end
        end
        if (in_ready) begin
          in_valid = vpat[pi % plen];
          pi++;
          if (in_valid) begin
            in_a = pa; in_b = pb; fires++; last_fire = cyc;
          end else begin
            in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
          end
          #1;
          check({nm, " tile_a"}, longint'(tile_a), in_valid ? longint'(pa) : 0);
          check({nm, " tile_b"}, longint'(tile_b), in_valid ? longint'(pb) : 0);
        end else begin
          in_valid = 1'($urandom_range(0, 1));
          in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
          #1;
          check({nm, " tile_a idle zero"}, longint'(tile_a), 0);
        end
      end
    end
    if (!done) begin
      check({nm, " timeout"}, 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    check({nm, " fire count"}, fires, k);
    if (k > 0) check({nm, " fire-to-valid latency"}, valid_cyc - last_fire, 3);
    else       check({nm, " zero-K valid cycle"}, valid_cyc, 1);
    if (exp_busy > 0) check({nm, " busy cycles"}, busy_cyc, exp_busy);
    start = 1'b0; res_ready = 1'b0; in_valid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       nm;
    int          k;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  vpat;
    int          plen;
    int          rdy_hold;
    int          poke;
    longint      expv;
    int          exp_busy;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"single", 1, 8'h01, 8'h02, 8'hFF, 1, 0, 0, 16, 4};
    vecs[1] = '{"signed_gaps", 3, 8'hFF, 8'h03, 8'h29, 6, 0, 0, -72, 0};
    vecs[2] = '{"max_k", 255, 8'h80, 8'h80, 8'hFF, 1, 0, 0, 33423360, 258};
    vecs[3] = '{"zero_k", 0, 8'h00, 8'h00, 8'hFF, 1, 0, 0, 0, 1};
    vecs[4] = '{"backpressure", 2, 8'h01, 8'h01, 8'hFF, 1, 5, 0, 16, 0};
    vecs[5] = '{"start_busy", 4, 8'h01, 8'h01, 8'h05, 3, 0, 3, 32, 0};

    reset_n = 1'b0; start = 1'b0; num_chunks = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset in_ready", in_ready, 0);
    check("reset res_valid", res_valid, 0);
    check("reset res_data", sres(res_data), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].nm, vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].vpat, vecs[i].plen,
              vecs[i].rdy_hold, vecs[i].poke, vecs[i].expv, vecs[i].exp_busy);
    end

    // Reset in the middle of a K=4 job after two fires.
    start = 1'b1; num_chunks = 8'd4;
    @(negedge clk);
    start = 1'b0;
    check("mid_reset in_ready before", in_ready, 1);
    in_valid = 1'b1; in_a = {pr{8'h05}}; in_b = {pr{8'h07}};
    repeat (2) @(negedge clk);
    in_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    check("mid_reset busy", busy, 0);
    check("mid_reset in_ready", in_ready, 0);
    check("mid_reset res_valid", res_valid, 0);
    check("mid_reset res_data", sres(res_data), 0);
    reset_n = 1'b1;
    @(negedge clk);
    run_job("after_reset", 1, 8'h02, 8'h03, 8'hFF, 1, 0, 0, 48, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
